// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the instruction/data memory port arbiter.
//   arb_state_t : arbiter FSM state (IDLE / FETCH / DATA)
//   owner_t     : which requester owns the outstanding transaction
//   TIMEOUT_DEF : default watchdog limit in wait cycles
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arb_wdog.sv
// ---------------------------------------------------------------------------
// mem_arb_wdog
// Wait-cycle counter guarding an outstanding memory transaction.
//   clk, rst   : clock, synchronous active-high reset
//   i_clr      : force the count to zero
//   i_load     : start a new transaction (count the first wait cycle)
//   i_en       : a wait cycle is in progress, advance the count
//   o_expired  : TIMEOUT wait cycles have elapsed without completion
// ---------------------------------------------------------------------------
module mem_arb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    // The count equals the number of wait cycles spent so far, including the
    // current one, so the first cycle after a grant already reads 1.
    assign w_expired = (r_cnt == CNT_W'(TIMEOUT));
    assign o_expired = w_expired;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(1);
        end else if (i_en && !w_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the fetch path (if_*) and the
// load/store path (d_*). One transaction at a time; data beats fetch.
//   clk, rst            : clock, synchronous active-high reset
//   if_req/if_addr      : fetch request, held until if_valid
//   if_kill             : redirect, discards the current/in-flight fetch
//   if_rdata/if_valid   : fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_be : load/store request, held until d_valid
//   d_rdata/d_valid     : load data (0 for stores) and completion pulse
//   mem_*               : registered memory request, held until ack/abort
//   mem_rdata/mem_ack   : memory response
//   stall_if/stall_mw   : pipeline freeze while a requester waits
//   bus_err             : one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall_if,
    output logic                stall_mw,
    output logic                bus_err
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    owner_t            w_owner;
    logic              r_kill;
    logic              w_kill;
    logic              w_grant_d;
    logic              w_grant_if;
    logic              w_busy;
    logic              w_expired;
    logic              w_wd_load;
    logic              w_wd_clr;
    logic              w_mem_req;

    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [BE_W-1:0]   r_mem_be;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_valid;
    logic              r_d_valid;
    logic              r_bus_err;

    // A requester whose valid is pulsing is still holding req for the
    // transaction that just finished; masking with the valid keeps it from
    // being re-granted in that cycle while the other side may be served.
    assign stall_if = if_req & ~r_if_valid;
    assign stall_mw = d_req & ~r_d_valid;

    assign w_busy     = (r_state != IDLE);
    assign w_grant_d  = (r_state == IDLE) && stall_mw;
    assign w_grant_if = (r_state == IDLE) && !stall_mw && stall_if && !if_kill;
    assign w_owner    = (r_state == FETCH) ? OWN_IF : OWN_D;
    // A kill arriving in the completing cycle must still suppress if_valid.
    assign w_kill     = r_kill | if_kill;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; ack and timeout both end the transaction
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next_state = DATA;
                end else if (w_grant_if) begin
                    w_next_state = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_ack || w_expired) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output / control decode from the state register
    always_comb begin
        w_mem_req = 1'b0;
        w_wd_load = 1'b0;
        w_wd_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                w_wd_load = w_grant_d || w_grant_if;
                w_wd_clr  = !(w_grant_d || w_grant_if);
            end
            FETCH, DATA: begin
                w_mem_req = 1'b1;
            end
            default: w_wd_clr = 1'b1;
        endcase
    end

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_wd_clr),
        .i_load    (w_wd_load),
        .i_en      (w_busy),
        .o_expired (w_expired)
    );

    // Request latch, response capture and kill flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_kill      <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_bus_err  <= 1'b0;

            if (w_grant_d) begin
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_mem_be    <= d_be;
            end else if (w_grant_if) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
                r_mem_be    <= '1;
            end

            if (w_busy && (mem_ack || w_expired)) begin
                // Ack has priority; a timeout only counts without an ack.
                r_bus_err <= !mem_ack;
                if (w_owner == OWN_IF) begin
                    if (!w_kill) begin
                        r_if_valid <= 1'b1;
                        r_if_rdata <= mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    r_d_valid <= 1'b1;
                    r_d_rdata <= (mem_ack && !r_mem_we) ? mem_rdata : '0;
                end
            end

            r_kill <= (r_state == FETCH) && (w_next_state == FETCH) && w_kill;
        end
    end

    assign mem_req   = w_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a short watchdog (TIMEOUT=8).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mw;
    logic        bus_err;

    int n_total = 0;
    int n_bad   = 0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_mw  (stall_mw),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_kill   = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_be      = 4'hF;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_mem_req",  32'(mem_req),  32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_d_valid",  32'(d_valid),  32'd0);
        check("rst_bus_err",  32'(bus_err),  32'd0);
        check("rst_mem_addr", mem_addr,      32'd0);
        check("rst_if_rdata", if_rdata,      32'd0);
        check("rst_d_rdata",  d_rdata,       32'd0);
        rst = 1'b0;
        tick();

        // Single fetch
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        check("f1_mem_req",  32'(mem_req),  32'd1);
        check("f1_mem_addr", mem_addr,      32'h100);
        check("f1_mem_we",   32'(mem_we),   32'd0);
        check("f1_mem_be",   32'(mem_be),   32'hF);
        check("f1_stall",    32'(stall_if), 32'd1);
        tick();
        check("f1_wait_req",   32'(mem_req),  32'd1);
        check("f1_wait_valid", 32'(if_valid), 32'd0);
        check("f1_wait_stall", 32'(stall_if), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0050_0093;
        tick();
        check("f1_valid",     32'(if_valid), 32'd1);
        check("f1_rdata",     if_rdata,      32'h0050_0093);
        check("f1_req_drop",  32'(mem_req),  32'd0);
        check("f1_stall_off", 32'(stall_if), 32'd0);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();
        check("f1_valid_once", 32'(if_valid), 32'd0);
        check("f1_no_regrant", 32'(mem_req),  32'd0);

        // Store
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2004;
        d_wdata = 32'hDEAD_BEEF;
        d_be    = 4'h3;
        tick();
        check("st_mem_req",   32'(mem_req), 32'd1);
        check("st_mem_we",    32'(mem_we),  32'd1);
        check("st_mem_be",    32'(mem_be),  32'h3);
        check("st_mem_wdata", mem_wdata,    32'hDEAD_BEEF);
        check("st_mem_addr",  mem_addr,     32'h2004);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        check("st_valid", 32'(d_valid), 32'd1);
        check("st_rdata", d_rdata,      32'd0);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = 4'hF;
        tick();
        check("st_valid_once", 32'(d_valid), 32'd0);

        // Simultaneous load and fetch: data first
        if_req = 1'b1;
        if_addr = 32'h104;
        d_req  = 1'b1;
        d_addr = 32'h2000;
        tick();
        check("sim_d_addr",   mem_addr,      32'h2000);
        check("sim_d_we",     32'(mem_we),   32'd0);
        check("sim_stall_if", 32'(stall_if), 32'd1);
        check("sim_stall_mw", 32'(stall_mw), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1122_3344;
        tick();
        check("sim_d_valid",  32'(d_valid),  32'd1);
        check("sim_d_rdata",  d_rdata,       32'h1122_3344);
        check("sim_if_early", 32'(if_valid), 32'd0);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        tick();
        check("sim_if_req",  32'(mem_req), 32'd1);
        check("sim_if_addr", mem_addr,     32'h104);
        mem_ack   = 1'b1;
        mem_rdata = 32'h00A0_0113;
        tick();
        check("sim_if_valid", 32'(if_valid), 32'd1);
        check("sim_if_rdata", if_rdata,      32'h00A0_0113);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();

        // Kill an in-flight fetch, then redirect to 0x200
        if_req  = 1'b1;
        if_addr = 32'h108;
        tick();
        check("kl_addr", mem_addr, 32'h108);
        if_kill = 1'b1;
        if_addr = 32'h200;
        tick();
        check("kl_addr_hold", mem_addr,      32'h108);
        check("kl_no_valid0", 32'(if_valid), 32'd0);
        if_kill = 1'b0;
        tick();
        check("kl_no_valid1", 32'(if_valid), 32'd0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        check("kl_no_valid2", 32'(if_valid), 32'd0);
        check("kl_req_drop",  32'(mem_req),  32'd0);
        check("kl_rdata_keep", if_rdata,     32'h00A0_0113);
        mem_ack = 1'b0;
        tick();
        check("kl_new_req",  32'(mem_req), 32'd1);
        check("kl_new_addr", mem_addr,     32'h200);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0013;
        tick();
        check("kl_new_valid", 32'(if_valid), 32'd1);
        check("kl_new_rdata", if_rdata,      32'h0000_0013);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();

        // Load timeout: mem_req held 8 cycles, then abort
        d_req  = 1'b1;
        d_addr = 32'h3000;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("to_wait%0d", i), 32'(mem_req | bus_err << 1), 32'd1);
        end
        tick();
        check("to_req_drop", 32'(mem_req), 32'd0);
        check("to_bus_err",  32'(bus_err), 32'd1);
        check("to_d_valid",  32'(d_valid), 32'd1);
        check("to_d_rdata",  d_rdata,      32'd0);
        d_req = 1'b0;
        tick();
        check("to_err_once", 32'(bus_err), 32'd0);
        check("to_idle",     32'(mem_req), 32'd0);

        // Ack arriving in the timeout cycle wins
        d_req  = 1'b1;
        d_addr = 32'h3004;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        check("tie_d_valid", 32'(d_valid), 32'd1);
        check("tie_d_rdata", d_rdata,      32'hCAFE_F00D);
        check("tie_bus_err", 32'(bus_err), 32'd0);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        tick();

        // Killed fetch that times out: bus_err only
        if_req  = 1'b1;
        if_addr = 32'h300;
        tick();
        if_kill = 1'b1;
        if_req  = 1'b0;
        tick();
        if_kill = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check("kto_still_req", 32'(mem_req), 32'd1);
        tick();
        check("kto_bus_err",  32'(bus_err),  32'd1);
        check("kto_no_valid", 32'(if_valid), 32'd0);
        check("kto_req_drop", 32'(mem_req),  32'd0);
        check("kto_rdata",    if_rdata,      32'h0000_0013);
        tick();
        check("kto_err_once", 32'(bus_err), 32'd0);

        // if_kill in IDLE blocks the fetch grant
        if_req  = 1'b1;
        if_addr = 32'h400;
        if_kill = 1'b1;
        tick();
        check("idle_kill_nogrant", 32'(mem_req), 32'd0);
        if_req  = 1'b0;
        if_kill = 1'b0;
        tick();

        // Reset two cycles into a load, then a stray ack
        d_req  = 1'b1;
        d_addr = 32'h4000;
        tick();
        tick();
        check("rm_busy", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        check("rm_req",      32'(mem_req),  32'd0);
        check("rm_d_valid",  32'(d_valid),  32'd0);
        check("rm_if_valid", 32'(if_valid), 32'd0);
        check("rm_bus_err",  32'(bus_err),  32'd0);
        check("rm_addr",     mem_addr,      32'd0);
        rst       = 1'b0;
        d_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        check("rm_stray_d",  32'(d_valid),  32'd0);
        check("rm_stray_if", 32'(if_valid), 32'd0);
        check("rm_stray_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
        tick();
        check("rm_d_rdata", d_rdata, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
